// File: rtl/instr_decode_stage_if.sv
// Fetch->decode->execute handshake bundle for instr_decode_stage (DECODER_M_EXT_EN adds out_muldiv).
// master = fetch/execute side, slave = the decode stage.
interface instr_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [2:0]       out_funct3;
  logic             out_alt;
  logic [XLEN-1:0]  out_imm;
  logic [3:0]       out_class;
  logic             out_regfile_we;
  logic             out_mem_re;
  logic             out_mem_we;
  logic             out_branch;
  logic             out_jump;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;
`ifdef DECODER_M_EXT_EN
  logic             out_muldiv;
`endif

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_alt,
           out_imm, out_class, out_regfile_we, out_mem_re, out_mem_we, out_branch,
           out_jump, out_illegal, illegal_cnt
`ifdef DECODER_M_EXT_EN
    , input out_muldiv
`endif
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_alt,
           out_imm, out_class, out_regfile_we, out_mem_re, out_mem_we, out_branch,
           out_jump, out_illegal, illegal_cnt
`ifdef DECODER_M_EXT_EN
    , output out_muldiv
`endif
  );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I/RV64I decode stage: single-entry register, decoded fields 1 cycle after accept.
// Holds output while out_ready is low (in_ready drops); flush wins; DECODER_M_EXT_EN decodes M-extension OP words.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  instr_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_LUI     = 4'd1;
  localparam logic [3:0] CLS_AUIPC   = 4'd2;
  localparam logic [3:0] CLS_JAL     = 4'd3;
  localparam logic [3:0] CLS_JALR    = 4'd4;
  localparam logic [3:0] CLS_BRANCH  = 4'd5;
  localparam logic [3:0] CLS_LOAD    = 4'd6;
  localparam logic [3:0] CLS_STORE   = 4'd7;
  localparam logic [3:0] CLS_OPIMM   = 4'd8;
  localparam logic [3:0] CLS_OP      = 4'd9;
  localparam logic [3:0] CLS_FENCE   = 4'd10;
  localparam logic [3:0] CLS_SYSTEM  = 4'd11;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] imm;
    logic [3:0]      cls;
    logic            regfile_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jump;
    logic            illegal;
`ifdef DECODER_M_EXT_EN
    logic            muldiv;
`endif
  } dec_t;

  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  dec_t             dec_d;
  dec_t             dec_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  logic [3:0]       cls;
  logic             legal;
  logic             wb;
  logic             muldiv;
  logic [31:0]      imm32;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    cls    = CLS_ILLEGAL;
    legal  = 1'b1;
    wb     = 1'b0;
    muldiv = 1'b0;
    imm32  = '0;
    case (opcode)
      OPC_LUI: begin
        cls = CLS_LUI; wb = 1'b1; imm32 = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        cls = CLS_AUIPC; wb = 1'b1; imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        cls = CLS_JAL; wb = 1'b1;
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        cls = CLS_JALR; wb = 1'b1; legal = (f3 == 3'b000);
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH; legal = !(f3 == 3'b010 || f3 == 3'b011);
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        cls = CLS_LOAD; wb = 1'b1;
        legal = (XLEN == 64) ? (f3 != 3'b111)
                             : !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        cls = CLS_STORE;
        legal = (XLEN == 64) ? (f3 <= 3'b011) : (f3 <= 3'b010);
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_OPIMM: begin
        cls = CLS_OPIMM; wb = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
        // RV64 shifts use a 6-bit shamt, so only instr[31:26] is funct
        if (f3 == 3'b001)
          legal = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (XLEN == 64) ? (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000)
                               : (f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OPC_OP: begin
        cls = CLS_OP; wb = 1'b1;
        if (f7 == 7'b0000000)
          legal = 1'b1;
        else if (f7 == 7'b0100000)
          legal = (f3 == 3'b000 || f3 == 3'b101);
`ifdef DECODER_M_EXT_EN
        else if (f7 == 7'b0000001)
          muldiv = 1'b1;
`endif
        else
          legal = 1'b0;
      end
      OPC_FENCE: cls = CLS_FENCE;
      OPC_SYSTEM: begin
        cls = CLS_SYSTEM;
        legal = (instr == 32'h0000_0073 || instr == 32'h0010_0073);
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      default: legal = 1'b0;
    endcase
    if (instr[1:0] != 2'b11 || instr == '0 || instr == '1)
      legal = 1'b0;

    dec_d        = '0;
    dec_d.pc     = bus.in_pc;
    dec_d.rd     = instr[11:7];
    dec_d.rs1    = instr[19:15];
    dec_d.rs2    = instr[24:20];
    dec_d.funct3 = f3;
    dec_d.alt    = instr[30];
    if (legal) begin
      dec_d.cls        = cls;
      dec_d.imm        = XLEN'($signed(imm32));
      dec_d.regfile_we = wb && (instr[11:7] != 5'd0);
      dec_d.mem_re     = (cls == CLS_LOAD);
      dec_d.mem_we     = (cls == CLS_STORE);
      dec_d.branch     = (cls == CLS_BRANCH);
      dec_d.jump       = (cls == CLS_JAL || cls == CLS_JALR);
`ifdef DECODER_M_EXT_EN
      dec_d.muldiv     = muldiv;
`endif
    end else begin
      dec_d.cls     = CLS_ILLEGAL;
      dec_d.illegal = 1'b1;
    end
  end

  assign bus.in_ready = (!valid_q || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // in_ready already excludes flush, so accept and flush never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.flush)
        valid_q <= 1'b0;
      else if (accept) begin
        valid_q <= 1'b1;
        dec_q   <= dec_d;
      end else if (bus.out_ready)
        valid_q <= 1'b0;
      if (accept && dec_d.illegal && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_pc         = dec_q.pc;
  assign bus.out_rd         = dec_q.rd;
  assign bus.out_rs1        = dec_q.rs1;
  assign bus.out_rs2        = dec_q.rs2;
  assign bus.out_funct3     = dec_q.funct3;
  assign bus.out_alt        = dec_q.alt;
  assign bus.out_imm        = dec_q.imm;
  assign bus.out_class      = dec_q.cls;
  assign bus.out_regfile_we = dec_q.regfile_we;
  assign bus.out_mem_re     = dec_q.mem_re;
  assign bus.out_mem_we     = dec_q.mem_we;
  assign bus.out_branch     = dec_q.branch;
  assign bus.out_jump       = dec_q.jump;
  assign bus.out_illegal    = dec_q.illegal;
  assign bus.illegal_cnt    = cnt_q;
`ifdef DECODER_M_EXT_EN
  assign bus.out_muldiv     = dec_q.muldiv;
`endif

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width; legal values 32 and 64; immediates and PC sign/zero-extend to XLEN.
REQ-002 Parameter CNT_W, default 16, meaning width of the saturating illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  discard the held decoded instruction.
REQ-006 in_valid  input  1  fetch presents an instruction.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 out_valid  output  1  decoded fields valid.
REQ-011 out_ready  input  1  execute consumes the decoded fields.
REQ-012 out_pc  output  XLEN  registered PC.
REQ-013 out_rd, out_rs1, out_rs2  output  5 each  register indices.
REQ-014 out_funct3  output  3; out_alt  output  1  (instr[30], SUB/SRA select).
REQ-015 out_imm  output  XLEN  sign-extended immediate.
REQ-016 out_class  output  4  LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILLEGAL encodings.
REQ-017 out_regfile_we, out_mem_re, out_mem_we, out_branch, out_jump, out_illegal  output  1 each  control signals.
REQ-018 illegal_cnt  output  CNT_W  count of illegal instructions accepted.

Function
REQ-019 Single-entry pipeline register: in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-020 Accept on in_valid && in_ready; decoded fields SHALL appear with out_valid=1 on the next edge (latency 1 cycle).
REQ-021 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-022 Consume without new accept SHALL clear out_valid next edge; consume with accept SHALL reload with no bubble.
REQ-023 flush SHALL clear out_valid next edge and take priority over any same-cycle accept or consume.
REQ-024 Immediates: I (LOAD, OPIMM, JALR, SYSTEM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); all sign-extended from instr[31] to XLEN; other classes imm=0.
REQ-025 out_regfile_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP only when rd!=0, else 0.
REQ-026 out_mem_re=1 for LOAD, out_mem_we=1 for STORE, out_branch=1 for BRANCH, out_jump=1 for JAL and JALR.
REQ-027 Illegal SHALL be: instr[1:0]!=2'b11; unknown opcode; BRANCH funct3 010/011; LOAD funct3 011/110/111 (XLEN=32) or 111 (XLEN=64); STORE funct3 >011 (XLEN=64) or >010 (XLEN=32); OP funct7 not 0000000 or 0100000, or 0100000 with funct3 not 000/101; OPIMM shift funct7 rule likewise; JALR funct3!=000; SYSTEM other than ECALL/EBREAK; all-zero and all-ones words.
REQ-028 Illegal instruction SHALL set out_class=ILLEGAL, out_illegal=1 and force regfile_we, mem_re, mem_we, branch, jump to 0.
REQ-029 illegal_cnt SHALL increment by 1 on each accepted illegal instruction and saturate at all-ones; a flushed illegal instruction still counts.
REQ-030 FENCE SHALL decode legal with all enables 0.

Reset
REQ-031 rst high SHALL immediately clear out_valid, illegal_cnt, and all out_* fields to 0; in_ready SHALL be 1 the first cycle after release.
REQ-032 rst asserted mid-transfer SHALL drop the held instruction with no output.

Configuration
REQ-033 Macro DECODER_M_EXT_EN: when defined, OP with funct7=0000001 (any funct3) SHALL decode legal as class OP with out_regfile_we per REQ-025 and output out_muldiv=1 (extra 1-bit port); when undefined, the port is absent and such words SHALL be illegal.

Verification
REQ-034 0x123450B7 accepted, out_ready=1 -> next cycle out_valid=1, class LUI, rd=1, imm=0x12345000, regfile_we=1.
REQ-035 0xFE010113 (addi sp,sp,-32) with out_ready=0 for 3 cycles -> fields stable, in_ready=0, imm=0xFFFFFFE0; release -> back-to-back accept, no bubble.
REQ-036 0x00000000 then 0xFFFFFFFF -> both out_illegal=1, all enables 0, illegal_cnt=2.
REQ-037 0x02A58533 (mul a0,a1,a0) -> legal, out_muldiv=1 with DECODER_M_EXT_EN; illegal without.
REQ-038 flush and in_valid same cycle with out_valid=1 -> out_valid=0 next cycle, new instruction dropped; rst pulse mid-stall -> all outputs 0 asynchronously.
REQ-039 Force illegal_cnt to all-ones (CNT_W=4, 16 illegal words) -> holds 0xF on 17th.
